// File: rtl/req_ack_window_pkg.sv
// req_ack_window_pkg: shared FSM state type, default window bounds, wrap-safe age helper
package req_ack_window_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, WINDOW} state_e;
  localparam int MIN_DLY_DEF = 1;
  localparam int MAX_DLY_DEF = 5;
  localparam int TS_MAX_W = 16;
  function automatic logic [TS_MAX_W-1:0] age_f(input logic [TS_MAX_W-1:0] now, input logic [TS_MAX_W-1:0] ts, input int w);
    return (now - ts) & ({TS_MAX_W{1'b1}} >> (TS_MAX_W - w));
  endfunction
endpackage

// File: rtl/req_ack_window_ctrl_ts_fifo.sv
// req_ack_window_ctrl_ts_fifo: DEPTH x W timestamp circular buffer (push/pop, head/next-head, count, full/empty)
module req_ack_window_ctrl_ts_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [W-1:0]               nxt,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_inc, wr_inc;
  assign rd_inc = (rd == AW'(DEPTH-1)) ? '0 : rd + 1'b1;
  assign wr_inc = (wr == AW'(DEPTH-1)) ? '0 : wr + 1'b1;
  assign head = mem[rd];
  assign nxt = mem[rd_inc];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= pop ? rd_inc : rd;
      wr <= push ? wr_inc : wr;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
endmodule

// File: rtl/req_ack_window_ctrl.sv
// req_ack_window_ctrl: acks each captured req once, MIN_DLY..MAX_DLY cycles after capture (forced at MAX_DLY)
module req_ack_window_ctrl
  import req_ack_window_pkg::*;
#(
  parameter int MIN_DLY = MIN_DLY_DEF,
  parameter int MAX_DLY = MAX_DLY_DEF,
  parameter int DEPTH = 8,
  parameter int TS_W = $clog2(MAX_DLY+1)+1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic                       ack_rdy,
  output logic                       ack,
  output logic                       forced,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       full,
  output logic                       overflow,
  input  logic                       ovf_clr
);
  localparam int CW = $clog2(DEPTH+1);
  state_e state, state_d;
  logic [TS_W-1:0] now, head_ts, nxt_ts, ts_d, age, age_d;
  logic empty, push, pop, drop, busy_d;
  req_ack_window_ctrl_ts_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(now),
    .head(head_ts), .nxt(nxt_ts), .count(pending), .full(full), .empty(empty)
  );
  assign age = TS_W'(age_f(TS_MAX_W'(now), TS_MAX_W'(head_ts), TS_W));
  assign ack = state == WINDOW && (ack_rdy || age == TS_W'(MAX_DLY));
  assign forced = ack && !ack_rdy;
  assign pop = ack;
  assign push = req && (!full || pop);
  assign drop = req && full && !pop;
  // State is registered, so derive it from the head that will be present after this edge and its age then.
  always_comb begin
    ts_d = pop ? (pending > CW'(1) ? nxt_ts : now) : (empty ? now : head_ts);
    busy_d = pop ? (pending > CW'(1) || push) : (!empty || push);
    age_d = TS_W'(age_f(TS_MAX_W'(now + 1'b1), TS_MAX_W'(ts_d), TS_W));
    state_d = !busy_d ? IDLE : (age_d < TS_W'(MIN_DLY) ? HOLD : WINDOW);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      now <= '0;
      state <= IDLE;
      overflow <= 1'b0;
    end else begin
      now <= now + 1'b1;
      state <= state_d;
      overflow <= drop || (overflow && !ovf_clr);
    end
`ifdef REQ_ACK_WINDOW_SVA_EN
  a_latency: assert property (@(posedge clk) disable iff (!rst_n) req && !full |-> ##[MIN_DLY:MAX_DLY] ack);
  a_ack_state: assert property (@(posedge clk) disable iff (!rst_n) !(ack && state != WINDOW));
  a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n) !$rose(overflow));
  a_pending: assert property (@(posedge clk) disable iff (!rst_n) pending <= CW'(DEPTH));
`else
`endif
endmodule

// File: tb/tb_req_ack_window_ctrl.sv
// tb_req_ack_window_ctrl: directed checks of window/forced acks, overflow, reset, MIN_DLY=2 hold
module tb_req_ack_window_ctrl;
  logic clk = 0, rst_n = 0, req = 0, ack_rdy = 0, ovf_clr = 0;
  logic a0, f0, fu0, o0, a4, f4, fu4, o4, a2, f2, fu2, o2;
  logic [3:0] p0, p2;
  logic [2:0] p4;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  req_ack_window_ctrl u0 (.clk(clk), .rst_n(rst_n), .req(req), .ack_rdy(ack_rdy), .ack(a0), .forced(f0),
    .pending(p0), .full(fu0), .overflow(o0), .ovf_clr(ovf_clr));
  req_ack_window_ctrl #(.DEPTH(4)) u4 (.clk(clk), .rst_n(rst_n), .req(req), .ack_rdy(ack_rdy), .ack(a4), .forced(f4),
    .pending(p4), .full(fu4), .overflow(o4), .ovf_clr(ovf_clr));
  req_ack_window_ctrl #(.MIN_DLY(2)) u2 (.clk(clk), .rst_n(rst_n), .req(req), .ack_rdy(ack_rdy), .ack(a2), .forced(f2),
    .pending(p2), .full(fu2), .overflow(o2), .ovf_clr(ovf_clr));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic r, input logic rdy);
    req = r;
    ack_rdy = rdy;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) tick();
    drive(1, 1);
    chk("rst_ack", a0, 0); chk("rst_forced", f0, 0); chk("rst_pending", p0, 0);
    chk("rst_full", fu0, 0); chk("rst_ovf", o0, 0);
    drive(0, 0);
    rst_n = 1;
    tick();
    drive(1, 1); chk("t1_ack_c2", a0, 0); tick();
    drive(0, 1); chk("t1_ack_c3", a0, 1); chk("t1_forced_c3", f0, 0); chk("t1_pend_c3", p0, 1);
    chk("t6_ack_c3", a2, 0); chk("t6_pend_c3", p2, 1); tick();
    drive(0, 1); chk("t1_ack_c4", a0, 0); chk("t1_pend_c4", p0, 0); chk("t6_ack_c4", a2, 1); tick();
    drive(0, 0); chk("t6_pend_c5", p2, 0); chk("t6_ack_c5", a2, 0); tick();
    drive(1, 0); tick();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0);
      chk("t2_ack", a0, 8'(k == 5));
      chk("t2_forced", f0, 8'(k == 5));
      tick();
    end
    chk("t2_pend_end", p0, 0);
    for (int k = 0; k <= 4; k++) begin
      drive(k < 4, 1);
      chk("t3_ack", a0, 8'(k > 0));
      chk("t3_pend", p0, 8'(k > 0));
      tick();
    end
    drive(0, 1); chk("t3_ack_end", a0, 0); chk("t3_pend_end", p0, 0);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0); tick();
    end
    drive(1, 0); chk("t4_full", fu4, 1); chk("t4_pend_full", p4, 4); chk("t4_ovf_pre", o4, 0); tick();
    for (int k = 5; k <= 8; k++) begin
      drive(0, 0);
      chk("t4_ack", a4, 1); chk("t4_forced", f4, 1); chk("t4_ovf", o4, 1); chk("t4_pend", p4, 8'(9 - k));
      tick();
    end
    drive(0, 0); chk("t4_ack_end", a4, 0); chk("t4_pend_end", p4, 0); chk("t4_ovf_hold", o4, 1);
    chk("t4_d8_no_ovf", o0, 0);
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("t4_ovf_clr", o4, 0);
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0); tick();
    end
    drive(0, 0); chk("t5_pend3", p0, 3); chk("t5_ack_rdy0", a0, 0);
    drive(0, 1); chk("t5_ack_pre", a0, 1);
    rst_n = 0; #1;
    chk("t5_ack_rst", a0, 0); chk("t5_pend_rst", p0, 0); chk("t5_forced_rst", f0, 0);
    tick();
    rst_n = 1;
    for (int k = 0; k < 7; k++) begin
      drive(0, 1); chk("t5_no_ack", a0, 0); chk("t5_no_pend", p0, 0); tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
